// File: rtl/io_uart_tx.sv
// io_uart_tx: FIFO-buffered 8N1 serial transmitter with back-pressure and a sticky overrun flag.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module io_uart_tx #(
   parameter int FIFO_AW  = 4,
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] uart_io_char,
   input  logic       uart_io_we,
   output logic       uart_io_full,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_fifo_overrun
);

   localparam int               DEPTH     = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0] CNT_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
   localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   function automatic logic parity8(input logic [7:0] b);
      return ^b;
   endfunction

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               full_q, overrun_q, busy_q, tx_q, tx_d;
   state_t             state_q, state_d;
   logic [7:0]         sh_q, sh_d;
   logic [15:0]        baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic               push_s, pop_s, baud_tc_s;
`ifdef UART_TX_PARITY_EN
   logic               par_q, par_d;
`endif

   assign push_s    = uart_io_we & ~full_q;
   assign baud_tc_s = (baud_q == BAUD_LAST);

   // FIFO occupancy after this cycle's push and pop
   always_comb begin
      count_d = count_q;
      if (push_s && !pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (!push_s && pop_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Serializer next state; a pop always loads the shift register and restarts the baud count
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop_s   = 1'b1;
               sh_d    = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
               par_d   = parity8(mem_q[rptr_q]);
`endif
               baud_d  = 16'd0;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (baud_tc_s) begin
               baud_d  = 16'd0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_tc_s) begin
               baud_d = 16'd0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  sh_d  = {1'b0, sh_q[7:1]};
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tc_s) begin
               baud_d  = 16'd0;
               state_d = S_STOP;
            end else begin
               baud_d  = baud_q + 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (baud_tc_s) begin
               baud_d = 16'd0;
               if (count_q != '0) begin
                  pop_s   = 1'b1;
                  sh_d    = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
                  par_d   = parity8(mem_q[rptr_q]);
`endif
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Line level follows the state being entered so tx stays a clean register output
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // Control and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sh_q      <= 8'd0;
         baud_q    <= 16'd0;
         bit_q     <= 3'd0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         wptr_q    <= push_s ? (wptr_q + PTR_ONE) : wptr_q;
         rptr_q    <= pop_s ? (rptr_q + PTR_ONE) : rptr_q;
         count_q   <= count_d;
         full_q    <= (count_d == FULL_CNT);
         overrun_q <= overrun_q | (uart_io_we & full_q);
         busy_q    <= (state_q != S_IDLE) | (count_q != '0);
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // FIFO storage; contents are don't-care once count is cleared
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_q[wptr_q] <= uart_io_char;
      end
   end

   assign uart_io_full    = full_q;
   assign tx              = tx_q;
   assign tx_busy         = busy_q;
   assign tx_fifo_overrun = overrun_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with a small FIFO and fast baud; a line receiver decodes frames.
`timescale 1ns/1ps
module tb_io_uart_tx;

   localparam int B  = 4;
   localparam int AW = 2;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * B;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ch  = 8'h00;
   logic       we  = 1'b0;
   logic       full, tx, busy, ovr;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   io_uart_tx #(.FIFO_AW(AW), .BAUD_DIV(B)) dut (
      .clk(clk), .rst(rst), .uart_io_char(ch), .uart_io_we(we),
      .uart_io_full(full), .tx(tx), .tx_busy(busy), .tx_fifo_overrun(ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line receiver: samples mid-bit on the falling clock edge
   logic [7:0] rx_data[$];
   bit         rx_ok[$];
   int         rx_start[$];
   bit         rx_act = 1'b0;
   int         rx_c, rx_k, rx_st;
   logic [7:0] rx_b;
   bit         rx_good;
   logic       rx_par = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         rx_act = 1'b0;
      end else begin
         if (!rx_act && tx === 1'b0) begin
            rx_act = 1'b1; rx_c = 0; rx_st = cyc; rx_good = 1'b1; rx_b = 8'h00;
         end
         if (rx_act) begin
            if (rx_c % B == B / 2) begin
               rx_k = rx_c / B;
               if (rx_k == 0) begin
                  if (tx !== 1'b0) rx_good = 1'b0;
               end else if (rx_k <= 8) begin
                  rx_b[rx_k-1] = tx;
               end else if (rx_k == NB - 1) begin
                  if (tx !== 1'b1) rx_good = 1'b0;
                  rx_data.push_back(rx_b); rx_ok.push_back(rx_good); rx_start.push_back(rx_st);
                  rx_act = 1'b0;
               end else begin
                  rx_par = tx;
                  if (tx !== ^rx_b) rx_good = 1'b0;
               end
            end
            rx_c++;
         end
      end
   end

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      logic r;
      if (k == 0) r = 1'b0;
      else if (k <= 8) r = b[k-1];
`ifdef UART_TX_PARITY_EN
      else if (k == 9) r = ^b;
`endif
      else r = 1'b1;
      return r;
   endfunction

   task automatic rx_clear();
      rx_data.delete(); rx_ok.delete(); rx_start.delete();
   endtask

   task automatic wait_frames(input int n, input int budget);
      int w = 0;
      while (rx_data.size() < n && w < budget) begin
         @(posedge clk); #1; w++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_chk++; if (ovr !== 1'b0)  begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ovr); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame(input string name, input logic [7:0] b);
      rx_clear();
      ch = b; we = 1'b1;
      @(posedge clk); #1;
      we = 1'b0;
      n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL %s_latency: tx got %b want 1 one cycle after write", name, tx); end
      for (int k = 0; k < FRAME; k++) begin
         @(posedge clk); #1;
         n_chk++;
         if (tx !== frame_bit(b, k / B)) begin
            n_fail++; $display("FAIL %s_tx_cycle%0d: got %b want %b", name, k, tx, frame_bit(b, k / B));
         end
      end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_stop: got %b want 1", name, busy); end
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b want 0", name, busy); end
      n_chk++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL %s_idle_tx: got %b want 1", name, tx); end
      n_chk++;
      if (rx_data.size() != 1 || rx_data[0] !== b || !rx_ok[0]) begin
         n_fail++; $display("FAIL %s_decode: got %0d frames first %h want 1 frame %h", name, rx_data.size(),
                            (rx_data.size() > 0) ? rx_data[0] : 8'hxx, b);
      end
   endtask

   task automatic test_back_to_back();
      rx_clear();
      ch = 8'hA3; we = 1'b1;
      @(posedge clk); #1;
      ch = 8'h0F;
      @(posedge clk); #1;
      we = 1'b0;
      wait_frames(2, 3 * FRAME);
      n_chk++;
      if (rx_data.size() != 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d frames want 2", rx_data.size());
      end else begin
         n_chk++; if (rx_data[0] !== 8'hA3 || !rx_ok[0]) begin n_fail++; $display("FAIL b2b_first: got %h want a3", rx_data[0]); end
         n_chk++; if (rx_data[1] !== 8'h0F || !rx_ok[1]) begin n_fail++; $display("FAIL b2b_second: got %h want 0f", rx_data[1]); end
         n_chk++;
         if (rx_start[1] - rx_start[0] != FRAME) begin
            n_fail++; $display("FAIL b2b_gap: start spacing got %0d want %0d", rx_start[1] - rx_start[0], FRAME);
         end
      end
      repeat (B + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_overrun();
      rx_clear();
      for (int i = 0; i < 5; i++) begin
         ch = 8'(8'h11 * (i + 1)); we = 1'b1;
         @(posedge clk); #1;
         if (i == 3) begin
            n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovr_full_early: got %b want 0", full); end
         end
      end
      n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovr_full: got %b want 1", full); end
      n_chk++; if (ovr !== 1'b0)  begin n_fail++; $display("FAIL ovr_pre: got %b want 0", ovr); end
      ch = 8'hEE;
      @(posedge clk); #1;
      we = 1'b0;
      n_chk++; if (ovr !== 1'b1)  begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr); end
      wait_frames(5, 6 * FRAME);
      repeat (2 * FRAME) @(posedge clk);
      #1;
      n_chk++;
      if (rx_data.size() != 5) begin
         n_fail++; $display("FAIL ovr_frames: got %0d want 5", rx_data.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (rx_data[i] !== 8'(8'h11 * (i + 1)) || !rx_ok[i]) begin
               n_fail++; $display("FAIL ovr_byte%0d: got %h want %h", i, rx_data[i], 8'(8'h11 * (i + 1)));
            end
         end
      end
      n_chk++; if (ovr !== 1'b1)  begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
   endtask

   task automatic test_reset_midframe();
      bit saw_low = 1'b0;
      rx_clear();
      for (int i = 0; i < 6; i++) begin
         ch = 8'(8'h80 + i); we = 1'b1;
         @(posedge clk); #1;
      end
      we = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_chk++; if (full !== 1'b1 || ovr !== 1'b1) begin n_fail++; $display("FAIL mid_pre: full %b ovr %b want 1 1", full, ovr); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL mid_tx: got %b want 1", tx); end
      n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", full); end
      n_chk++; if (ovr !== 1'b0)  begin n_fail++; $display("FAIL mid_ovr: got %b want 0", ovr); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      rx_clear();
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      n_chk++; if (saw_low || rx_data.size() != 0) begin n_fail++; $display("FAIL mid_quiet: tx low %b frames %0d want 0 0", saw_low, rx_data.size()); end
   endtask

   task automatic test_parity();
      test_single_frame("parity", 8'h07);
`ifdef UART_TX_PARITY_EN
      n_chk++; if (rx_par !== 1'b1) begin n_fail++; $display("FAIL parity_bit: got %b want 1", rx_par); end
`endif
   endtask

   task automatic test_wrap();
      int w;
      rx_clear();
      for (int i = 0; i < 20; i++) begin
         we = 1'b0; w = 0;
         while (full === 1'b1 && w < 4 * FRAME) begin
            @(posedge clk); #1; w++;
         end
         n_chk++; if (w >= 4 * FRAME) begin n_fail++; $display("FAIL wrap_stall%0d: full %b want 0", i, full); end
         ch = 8'(i); we = 1'b1;
         @(posedge clk); #1;
      end
      we = 1'b0;
      wait_frames(20, 22 * FRAME);
      n_chk++;
      if (rx_data.size() != 20) begin
         n_fail++; $display("FAIL wrap_count: got %0d want 20", rx_data.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            n_chk++;
            if (rx_data[i] !== 8'(i) || !rx_ok[i]) begin
               n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx_data[i], 8'(i));
            end
         end
      end
      n_chk++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL wrap_ovr: got %b want 0", ovr); end
   endtask

   initial begin
      test_reset();
      test_single_frame("frame55", 8'h55);
      test_back_to_back();
      test_overrun();
      test_reset_midframe();
      test_parity();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Serial transmit end of the CPU I/O UART character path.
- Consumes the byte stream that io_uart_out drives on uart_io_char / uart_io_we, and returns back-pressure on uart_io_full.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on the tx pin.
- Sits in the clk domain beside io_uart_out and drives the board tx line when the CPU owns the console.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (16).
- BAUD_DIV, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- uart_io_char  input  8  byte to transmit.
- uart_io_we  input  1  write strobe; one byte per cycle while high.
- uart_io_full  output  1  FIFO full, registered.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- tx_fifo_overrun  output  1  sticky: a write arrived while full.

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high on rst.
- On rst: tx=1, uart_io_full=0, tx_busy=0, tx_fifo_overrun=0, FIFO pointers and count=0, state=IDLE, baud counter=0, bit counter=0.
- rst mid-frame aborts immediately: tx=1 on the next cycle and FIFO contents are discarded.

FIFO:
- Registered count of width FIFO_AW+1; pointers wrap modulo depth.
- Push when uart_io_we=1 and the registered uart_io_full=0.
- uart_io_full = (count==2**FIFO_AW), registered, so it reflects the count after this cycle's push/pop.
- A write seen while uart_io_full=1 is dropped and sets tx_fifo_overrun=1 until rst. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pop only occurs in the serializer load cycle; popping an empty FIFO is impossible by construction.

Serializer FSM (states IDLE, START, DATA, STOP):
- IDLE: tx=1. If count!=0, pop the head into shift register sh[7:0], clear the baud counter, go to START.
- START: tx=0 for BAUD_DIV cycles, then go to DATA with bit counter=0.
- DATA: tx=sh[0], LSB first. Every BAUD_DIV cycles shift right and increment the bit counter. After bit 7 has been held BAUD_DIV cycles, go to STOP.
- STOP: tx=1 for BAUD_DIV cycles. At the end, if count!=0, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- The baud counter counts 0..BAUD_DIV-1 and the state/bit advance happens at terminal count. Frame length is exactly 10*BAUD_DIV cycles.
- tx is a registered output.

Latency and status:
- With FSM in IDLE and FIFO empty, a write in cycle N makes count=1 at N+1. The FSM pops at N+1, and tx falls at N+2.
- tx_busy = (state!=IDLE) | (count!=0), registered.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for BAUD_DIV cycles. Frame = 11*BAUD_DIV cycles.
- Undefined: no PARITY state, 8N1, 10*BAUD_DIV cycles. Ports are identical in both builds.

Test Plan:
1. BAUD_DIV=4, rst, write 0x55 at cycle N -> tx falls at N+2. Over 40 cycles tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each held 4 cycles. tx_busy drops 1 cycle after the stop bit ends.
2. BAUD_DIV=4, write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back, no idle cycle between stop of the first and start of the second. Bits decode to 0xA3 then 0x0F.
3. FIFO_AW=2, BAUD_DIV=100, write 5 bytes consecutively -> the first pops immediately. uart_io_full=1 after the 5th write is accepted. A 6th write is dropped and tx_fifo_overrun=1 and stays 1. Exactly 5 frames are transmitted.
4. Full FIFO, assert rst during the DATA state of a frame -> next cycle tx=1, uart_io_full=0, tx_fifo_overrun=0, tx_busy=0. No further frames are transmitted.
5. UART_TX_PARITY_EN defined, BAUD_DIV=4, write 0x07 -> 44-cycle frame. Parity bit = 1 (three ones), then the stop bit.
6. Wrap-around: FIFO_AW=2, stream 20 bytes 0x00..0x13 with writes gated on !uart_io_full -> all 20 received in order, tx_fifo_overrun=0.
